// File: rtl/servo_pkg.sv
// Shared servo definitions: decoder FSM states, default limits and the nominal
// frame length also used by the PWM generator.
package servo_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2
   } dec_state_t;

   localparam logic [12:0] TIMEOUT_DEF   = 13'd3000;
   localparam logic [7:0]  MAX_WIDTH_DEF = 8'd255;
   localparam logic [12:0] FRAME_NOM     = 13'd1500;

endpackage

// File: rtl/servo_in_sync.sv
// Two-flop synchronizer for the servo PWM input, with an optional 3-cycle
// glitch filter enabled by defining SERVO_DEC_GLITCH_FILTER_EN.
module servo_in_sync (
   input  logic clkin,
   input  logic rstn,
   input  logic pwmin,
   output logic s,
   output logic s_vld
);

   logic sync_p0, sync_p1;
   logic vld_p0, vld_p1;

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
         vld_p0  <= 1'b0;
         vld_p1  <= 1'b0;
      end else begin
         sync_p0 <= pwmin;
         sync_p1 <= sync_p0;
         vld_p0  <= 1'b1;
         vld_p1  <= vld_p0;
      end
   end

`ifdef SERVO_DEC_GLITCH_FILTER_EN
   logic [1:0] hist_p2, hvld_p2;
   logic       flt_p3, fvld_p3;
   logic       all_vld, hold_hi, hold_lo;

   // Current sample plus two previous ones must agree before the output moves.
   assign all_vld = vld_p1 & (&hvld_p2);
   assign hold_hi = all_vld & sync_p1 & (&hist_p2);
   assign hold_lo = all_vld & ~sync_p1 & ~(|hist_p2);

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         hist_p2 <= 2'b00;
         hvld_p2 <= 2'b00;
         flt_p3  <= 1'b0;
         fvld_p3 <= 1'b0;
      end else begin
         hist_p2 <= {hist_p2[0], sync_p1};
         hvld_p2 <= {hvld_p2[0], vld_p1};
         if (hold_hi)
            flt_p3 <= 1'b1;
         else if (hold_lo)
            flt_p3 <= 1'b0;
         if (hold_hi | hold_lo)
            fvld_p3 <= 1'b1;
      end
   end

   assign s     = flt_p3;
   assign s_vld = fvld_p3;
`else
   assign s     = sync_p1;
   assign s_vld = vld_p1;
`endif

endmodule

// File: rtl/servo_pulse_decoder.sv
// Servo PWM decoder: measures high width and rise-to-rise frame length,
// flags overflow and loss of signal. Optional filter: SERVO_DEC_GLITCH_FILTER_EN.
module servo_pulse_decoder
   import servo_pkg::*;
#(
   parameter logic [12:0] TIMEOUT   = TIMEOUT_DEF,
   parameter logic [7:0]  MAX_WIDTH = MAX_WIDTH_DEF
) (
   input  logic        clkin,
   input  logic        rstn,
   input  logic        pwmin,
   output logic [7:0]  cntout,
   output logic [12:0] period,
   output logic        valid,
   output logic        ovf,
   output logic        lost
);

   logic s, s_vld;

   servo_in_sync u_sync (
      .clkin (clkin),
      .rstn  (rstn),
      .pwmin (pwmin),
      .s     (s),
      .s_vld (s_vld)
   );

   logic        samp_p2, samp_p3, vld_p2, vld_p3;
   dec_state_t  state, state_nxt;
   logic [7:0]  wcnt;
   logic [12:0] pcnt, hold;
   logic        have_rise, over;
   logic        rise, fall, start, finish, tmo;

   // Edges need two trusted samples so reset-time zeros never look like a fall.
   assign rise = vld_p3 & samp_p2 & ~samp_p3;
   assign fall = vld_p3 & ~samp_p2 & samp_p3;

   always_comb begin
      state_nxt = state;
      start     = 1'b0;
      finish    = 1'b0;
      tmo       = 1'b0;
      unique case (state)
         SYNC: if (vld_p2 && !samp_p2) state_nxt = LOW;
         LOW: if (rise) begin
            state_nxt = HIGH;
            start     = 1'b1;
         end
         HIGH: if (fall) begin
            state_nxt = LOW;
            finish    = 1'b1;
         end
         default: state_nxt = SYNC;
      endcase
      if (state != SYNC && !start && pcnt >= TIMEOUT) begin
         tmo       = 1'b1;
         finish    = 1'b0;
         state_nxt = SYNC;
      end
   end

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn)
         state <= SYNC;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clkin or negedge rstn) begin
      if (!rstn) begin
         samp_p2   <= 1'b0;
         samp_p3   <= 1'b0;
         vld_p2    <= 1'b0;
         vld_p3    <= 1'b0;
         wcnt      <= 8'd0;
         pcnt      <= 13'd0;
         hold      <= 13'd0;
         have_rise <= 1'b0;
         over      <= 1'b0;
         cntout    <= 8'd0;
         period    <= 13'd0;
         valid     <= 1'b0;
         ovf       <= 1'b0;
         lost      <= 1'b0;
      end else begin
         samp_p2 <= s;
         samp_p3 <= samp_p2;
         vld_p2  <= s_vld;
         vld_p3  <= vld_p2;
         valid   <= finish;

         if (state == SYNC)
            pcnt <= 13'd0;
         else if (start)
            pcnt <= 13'd1;
         else if (pcnt != 13'h1FFF)
            pcnt <= pcnt + 13'd1;

         if (start) begin
            wcnt      <= 8'd1;
            over      <= 1'b0;
            hold      <= have_rise ? pcnt : 13'd0;
            have_rise <= 1'b1;
         end else if (state == HIGH && samp_p2) begin
            if (wcnt == MAX_WIDTH)
               over <= 1'b1;
            else
               wcnt <= wcnt + 8'd1;
         end

         if (finish) begin
            cntout <= wcnt;
            period <= hold;
            ovf    <= over;
            lost   <= 1'b0;
         end

         // After a loss the next frame restarts as if it were the first one.
         if (tmo) begin
            lost      <= 1'b1;
            have_rise <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_servo_pulse_decoder.sv
// Self-checking bench for servo_pulse_decoder: directed frame table, multi-cycle
// corner sequences and randomized frames against a frame-level reference model.
module tb_servo_pulse_decoder;
   import servo_pkg::*;

   logic        clkin = 1'b0;
   logic        rstn  = 1'b0;
   logic        pwmin = 1'b0;
   logic [7:0]  cntout;
   logic [12:0] period;
   logic        valid, ovf, lost;

   servo_pulse_decoder dut (
      .clkin  (clkin),
      .rstn   (rstn),
      .pwmin  (pwmin),
      .cntout (cntout),
      .period (period),
      .valid  (valid),
      .ovf    (ovf),
      .lost   (lost)
   );

   always #5 clkin = ~clkin;

   typedef struct packed {
      logic [7:0]  cnt;
      logic [12:0] per;
      logic        ovf;
      logic        lst;
   } rep_t;

   typedef struct {
      int hi;
      int lo;
      int cnt;
      int per;
      int ovf;
   } vec_t;

   rep_t got_q[$];
   rep_t exp_q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always @(negedge clkin) begin
      if (valid === 1'b1)
         got_q.push_back('{cntout, period, ovf, lost});
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic frame(input int hi, input int lo);
      pwmin = 1'b1;
      repeat (hi) @(posedge clkin);
      #1 pwmin = 1'b0;
      repeat (lo) @(posedge clkin);
      #1;
   endtask

   task automatic expect_one(input string name, input int cnt, input int per,
                             input int ov, input bit per_chk);
      rep_t r;
      chk({name, "_nvalid"}, got_q.size(), 1);
      if (got_q.size() > 0) begin
         r = got_q.pop_front();
         chk({name, "_cntout"}, r.cnt, cnt);
         if (per_chk) chk({name, "_period"}, r.per, per);
         chk({name, "_ovf"}, r.ovf, ov);
         chk({name, "_lost"}, r.lst, 0);
      end
      got_q.delete();
   endtask

   task automatic check_zero(input string name);
      chk({name, "_cntout"}, cntout, 0);
      chk({name, "_period"}, period, 0);
      chk({name, "_valid"}, valid, 0);
      chk({name, "_ovf"}, ovf, 0);
      chk({name, "_lost"}, lost, 0);
   endtask

   task automatic do_reset();
      pwmin = 1'b0;
      rstn  = 1'b0;
      repeat (3) @(posedge clkin);
      #1 rstn = 1'b1;
      repeat (20) @(posedge clkin);
      #1;
      got_q.delete();
      exp_q.delete();
   endtask

   vec_t tbl[6];

   initial begin
      int lat, hi, lo, prev, ncmp_q;
      rep_t g, e;

      tbl[0] = '{100,  1401, 100, 0,    0};
      tbl[1] = '{100,  1401, 100, 1501, 0};
      tbl[2] = '{300,  200,  255, 1501, 1};
      tbl[3] = '{50,   100,  50,  500,  0};
      tbl[4] = '{60,   40,   60,  150,  0};
      tbl[5] = '{2000, 500,  255, 100,  1};

      // Reset state
      #2;
      check_zero("reset");
      do_reset();

      for (int i = 0; i < 6; i++) begin
         frame(tbl[i].hi, tbl[i].lo);
         expect_one($sformatf("tbl%0d", i), tbl[i].cnt, tbl[i].per, tbl[i].ovf, 1'b1);
         chk($sformatf("tbl%0d_lost_now", i), lost, 0);
      end

      // Falling-edge to valid latency
      pwmin = 1'b1;
      repeat (20) @(posedge clkin);
      #1 pwmin = 1'b0;
      got_q.delete();
      lat = -1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clkin);
         #1;
         if (valid === 1'b1 && lat < 0) lat = k;
      end
`ifdef SERVO_DEC_GLITCH_FILTER_EN
      chk("latency", lat, 6);
`else
      chk("latency", lat, 3);
`endif
      chk("latency_cntout", cntout, 20);
      repeat (50) @(posedge clkin);
      #1 got_q.delete();

      // Loss of signal
      frame(70, 3100);
      expect_one("pre_lost", 70, 0, 0, 1'b0);
      chk("lost_set", lost, 1);
      chk("lost_cntout_held", cntout, 70);
      frame(80, 50);
      expect_one("after_lost", 80, 0, 0, 1'b0);
      chk("lost_cleared", lost, 0);

      // Single-cycle spike, then a normal pulse
      frame(1, 50);
`ifdef SERVO_DEC_GLITCH_FILTER_EN
      chk("spike_ignored", got_q.size(), 0);
      got_q.delete();
`else
      expect_one("spike", 1, 0, 0, 1'b0);
`endif
      frame(60, 50);
      expect_one("after_spike", 60, 0, 0, 1'b0);

      // Reset in the middle of a pulse, released while still high
      pwmin = 1'b1;
      repeat (40) @(posedge clkin);
      #1 rstn = 1'b0;
      #1;
      check_zero("rst_mid");
      repeat (2) @(posedge clkin);
      #1 rstn = 1'b1;
      got_q.delete();
      repeat (80) @(posedge clkin);
      #1 pwmin = 1'b0;
      repeat (50) @(posedge clkin);
      #1;
      chk("rst_mid_novalid", got_q.size(), 0);
      frame(120, 50);
      expect_one("rst_next", 120, 0, 0, 1'b1);

      // Randomized frames against the frame-level model
      do_reset();
      prev = 0;
      for (int i = 0; i < 25; i++) begin
         if ($urandom_range(0, 3) == 0)
            hi = int'($urandom_range(260, 400));
         else
            hi = int'($urandom_range(3, 200));
         lo = int'($urandom_range(3, int'(FRAME_NOM)));
         e.cnt = (hi > int'(MAX_WIDTH_DEF)) ? MAX_WIDTH_DEF : 8'(hi);
         e.per = 13'(prev);
         e.ovf = (hi > int'(MAX_WIDTH_DEF));
         e.lst = 1'b0;
         exp_q.push_back(e);
         prev = hi + lo;
         frame(hi, lo);
      end
      repeat (10) @(posedge clkin);
      #1;
      chk("rand_nvalid", got_q.size(), exp_q.size());
      ncmp_q = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < ncmp_q; i++) begin
         g = got_q[i];
         e = exp_q[i];
         chk($sformatf("rand%0d_cntout", i), g.cnt, e.cnt);
         chk($sformatf("rand%0d_period", i), g.per, e.per);
         chk($sformatf("rand%0d_ovf", i), g.ovf, e.ovf);
         chk($sformatf("rand%0d_lost", i), g.lst, e.lst);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
